// File: rtl/imsic_msi_tx.sv
// -----------------------------------------------------------------------------
// imsic_msi_tx
//
// Upstream feeder for the per-hart IMSIC CSR gate. Incoming MSI writes
// (seteipnum_le) arrive on a valid/ready port. Each write is decoded into a
// target hart and interrupt file, and writes that cannot name a real
// interrupt are dropped and counted. Legal MSIs are buffered in a small FIFO
// and replayed one at a time as {hart, file, setipnum}. Each replay is a
// timed valid pulse, followed by a hold window so that a consumer which
// synchronises the valid and samples info on its falling edge always sees
// stable data.
//
// Ports
//   clk             single clock
//   rstn            asynchronous active-low reset
//   i_wr_vld        MSI write request
//   o_wr_rdy        write accepted on an edge where i_wr_vld & o_wr_rdy
//   i_wr_addr       byte address within the IMSIC region
//   i_wr_data       written identity
//   o_msi_info      {hart, file, setipnum} of the MSI being delivered
//   o_msi_info_vld  delivery pulse to the CSR gate
//   o_drop_cnt      saturating count of illegal writes that were accepted
//   o_busy          FIFO non-empty or delivery in progress
// -----------------------------------------------------------------------------
module imsic_msi_tx #(
  parameter int NR_INTP_FILES  = 7,
  parameter int NR_HARTS       = 4,
  parameter int NR_HARTS_WIDTH = 2,
  parameter int NR_SRC         = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int VLD_HIGH_CYC   = 2,
  parameter int HOLD_CYC       = 8,
  localparam int NR_SRC_WIDTH    = $clog2(NR_SRC),
  localparam int INTP_FILE_WIDTH = $clog2(NR_INTP_FILES),
  localparam int MSI_INFO_WIDTH  = NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_wr_vld,
  output logic                      o_wr_rdy,
  input  logic [31:0]               i_wr_addr,
  input  logic [31:0]               i_wr_data,
  output logic [MSI_INFO_WIDTH-1:0] o_msi_info,
  output logic                      o_msi_info_vld,
  output logic [7:0]                o_drop_cnt,
  output logic                      o_busy
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int MAX_CYC = (VLD_HIGH_CYC > HOLD_CYC) ? VLD_HIGH_CYC : HOLD_CYC;
  localparam int CYC_W   = $clog2(MAX_CYC + 1);
  localparam int HART_LSB = 12 + INTP_FILE_WIDTH;
  localparam int ADDR_USED_MSB = HART_LSB + NR_HARTS_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    HOLD
  } state_t;

  // ---------------------------------------------------------------------------
  // Address/data decode and legality filter
  // ---------------------------------------------------------------------------
  logic [INTP_FILE_WIDTH-1:0] wr_file;
  logic [NR_HARTS_WIDTH-1:0]  wr_hart;
  logic                       wr_legal;
  logic                       wr_accept;
  logic                       push;
  logic                       drop;
  logic [MSI_INFO_WIDTH-1:0]  push_data;
  logic                       unused_addr_bits;

  assign wr_file = i_wr_addr[12 +: INTP_FILE_WIDTH];
  assign wr_hart = i_wr_addr[HART_LSB +: NR_HARTS_WIDTH];

  // Address bits above the hart field carry no meaning for this block.
  assign unused_addr_bits = ^i_wr_addr[31:ADDR_USED_MSB+1];

  // Identity 0 is reserved and identities at or above NR_SRC do not exist,
  // so both are treated as illegal alongside misaligned/out-of-range targets.
  assign wr_legal = (i_wr_addr[11:0] == 12'd0)
                 && (32'(wr_file) < 32'(NR_INTP_FILES))
                 && (32'(wr_hart) < 32'(NR_HARTS))
                 && (i_wr_data != 32'd0)
                 && (i_wr_data < 32'(NR_SRC));

  assign wr_accept = i_wr_vld && o_wr_rdy;
  assign push      = wr_accept && wr_legal;
  assign drop      = wr_accept && !wr_legal;
  assign push_data = {wr_hart, wr_file, i_wr_data[NR_SRC_WIDTH-1:0]};

  // ---------------------------------------------------------------------------
  // MSI FIFO
  // ---------------------------------------------------------------------------
  logic [MSI_INFO_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      pop;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));

  // Ready depends only on the registered count, so a pop in the same cycle
  // never opens room for a push; this keeps o_wr_rdy free of FSM paths.
  assign o_wr_rdy = !fifo_full;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Delivery FSM
  // ---------------------------------------------------------------------------
  state_t                    state;
  state_t                    state_nx;
  logic [CYC_W-1:0]          cyc_cnt;
  logic [CYC_W-1:0]          cyc_cnt_nx;
  logic                      vld_q;
  logic                      vld_nx;
  logic [MSI_INFO_WIDTH-1:0] info_q;
  logic [MSI_INFO_WIDTH-1:0] info_nx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      vld_q   <= 1'b0;
      info_q  <= '0;
    end else begin
      state   <= state_nx;
      cyc_cnt <= cyc_cnt_nx;
      vld_q   <= vld_nx;
      info_q  <= info_nx;
    end
  end

  // cyc_cnt restarts at zero on every state entry and marks the last cycle of
  // HIGH/HOLD at N-1. Leaving HOLD with a queued MSI goes straight to HIGH so
  // back-to-back pulses are exactly VLD_HIGH_CYC+HOLD_CYC cycles apart.
  always_comb begin
    state_nx   = state;
    cyc_cnt_nx = cyc_cnt;
    vld_nx     = vld_q;
    info_nx    = info_q;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          info_nx    = fifo_mem[rd_ptr];
          vld_nx     = 1'b1;
          cyc_cnt_nx = '0;
          state_nx   = HIGH;
        end
      end
      HIGH: begin
        if (cyc_cnt == CYC_W'(VLD_HIGH_CYC - 1)) begin
          vld_nx     = 1'b0;
          cyc_cnt_nx = '0;
          state_nx   = HOLD;
        end else begin
          cyc_cnt_nx = cyc_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (cyc_cnt == CYC_W'(HOLD_CYC - 1)) begin
          cyc_cnt_nx = '0;
          if (!fifo_empty) begin
            pop      = 1'b1;
            info_nx  = fifo_mem[rd_ptr];
            vld_nx   = 1'b1;
            state_nx = HIGH;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cyc_cnt_nx = cyc_cnt + 1'b1;
        end
      end
      default: begin
        state_nx   = IDLE;
        cyc_cnt_nx = '0;
        vld_nx     = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Drop counter (saturating)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_drop_cnt <= 8'd0;
    end else if (drop && (o_drop_cnt != 8'hFF)) begin
      o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end

  assign o_msi_info     = info_q;
  assign o_msi_info_vld = vld_q;
  assign o_busy         = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_imsic_msi_tx.sv
// -----------------------------------------------------------------------------
// tb_imsic_msi_tx
//
// Directed self-checking bench for imsic_msi_tx with default parameters
// (info = {hart[9:8], file[7:5], id[4:0]}). A negedge monitor records every
// rising edge of o_msi_info_vld (cycle and info), the length of each high
// phase, and any change of o_msi_info during the hold window that follows.
// -----------------------------------------------------------------------------
module tb_imsic_msi_tx;

  localparam int HOLD_CYC = 8;

  logic        clk;
  logic        rstn;
  logic        i_wr_vld;
  logic        o_wr_rdy;
  logic [31:0] i_wr_addr;
  logic [31:0] i_wr_data;
  logic [9:0]  o_msi_info;
  logic        o_msi_info_vld;
  logic [7:0]  o_drop_cnt;
  logic        o_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;
  int rdy_waits = 0;

  int rise_cyc_q[$];
  int rise_info_q[$];
  int high_q[$];
  int stab_err = 0;
  int high_run = 0;
  int hold_left = 0;
  int last_info = 0;
  logic prev_vld = 1'b0;

  imsic_msi_tx dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_wr_vld       (i_wr_vld),
    .o_wr_rdy       (o_wr_rdy),
    .i_wr_addr      (i_wr_addr),
    .i_wr_data      (i_wr_data),
    .o_msi_info     (o_msi_info),
    .o_msi_info_vld (o_msi_info_vld),
    .o_drop_cnt     (o_drop_cnt),
    .o_busy         (o_busy)
  );

  // Free-running clock and edge counter; cyc read at a negedge is the number
  // of the posedge just before it.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampling half a cycle after each active edge.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_vld  = 1'b0;
      high_run  = 0;
      hold_left = 0;
    end else begin
      if (o_msi_info_vld) begin
        if (!prev_vld) begin
          rise_cyc_q.push_back(cyc);
          rise_info_q.push_back(int'(o_msi_info));
          last_info = int'(o_msi_info);
          high_run  = 0;
        end
        high_run++;
      end else begin
        if (prev_vld) begin
          high_q.push_back(high_run);
          hold_left = HOLD_CYC;
        end
        if (hold_left > 0) begin
          if (int'(o_msi_info) != last_info) stab_err++;
          hold_left--;
        end
      end
      prev_vld = o_msi_info_vld;
    end
  end

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one write from a negedge, holds it until ready, and returns at
  // the negedge after the accepting posedge with last_acc set to that edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    int guard;
    guard = 0;
    i_wr_vld  = 1'b1;
    i_wr_addr = addr;
    i_wr_data = data;
    while (!o_wr_rdy && guard < 200) begin
      @(negedge clk);
      guard++;
      rdy_waits++;
    end
    if (guard >= 200) checkOutput("wr_rdy_timeout", 32'd0, 32'd1);
    @(negedge clk);
    last_acc = cyc;
    i_wr_vld = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearMonitor();
    rise_cyc_q.delete();
    rise_info_q.delete();
    high_q.delete();
    stab_err = 0;
  endtask

  function automatic int qAt(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  int e0;
  int guard;
  logic [31:0] t3_addr [6] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_8000,
                               32'h0001_6000, 32'h0001_D000, 32'h0002_3000};
  logic [31:0] t3_data [6] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd31, 32'd6};
  int          t3_info [6] = '{'h001, 'h022, 'h103, 'h2C4, 'h3BF, 'h066};

  initial begin
    rstn      = 1'b0;
    i_wr_vld  = 1'b0;
    i_wr_addr = 32'd0;
    i_wr_data = 32'd0;
    waitCycles(3);
    rstn = 1'b1;
    waitCycles(1);

    // Reset state
    checkOutput("rst_vld",  32'(o_msi_info_vld), 32'd0);
    checkOutput("rst_info", 32'(o_msi_info),     32'd0);
    checkOutput("rst_drop", 32'(o_drop_cnt),     32'd0);
    checkOutput("rst_busy", 32'(o_busy),         32'd0);
    checkOutput("rst_rdy",  32'(o_wr_rdy),       32'd1);

    // Single legal MSI: hart1 file1 id5
    clearMonitor();
    applyStimulus(32'h0000_9000, 32'd5);
    e0 = last_acc;
    checkOutput("t1_busy_during", 32'(o_busy), 32'd1);
    waitCycles(20);
    checkOutput("t1_pulses",   32'(rise_cyc_q.size()), 32'd1);
    checkOutput("t1_latency",  32'(qAt(rise_cyc_q, 0) - e0), 32'd1);
    checkOutput("t1_info",     32'(qAt(rise_info_q, 0)), 32'h125);
    checkOutput("t1_high_len", 32'(qAt(high_q, 0)), 32'd2);
    checkOutput("t1_hold_stable_errs", 32'(stab_err), 32'd0);
    checkOutput("t1_busy_after", 32'(o_busy), 32'd0);
    checkOutput("t1_info_retained", 32'(o_msi_info), 32'h125);

    // Illegal writes: id 0, id 32, misaligned, file 7
    clearMonitor();
    rdy_waits = 0;
    applyStimulus(32'h0000_9000, 32'd0);
    applyStimulus(32'h0000_9000, 32'd32);
    applyStimulus(32'h0000_9004, 32'd5);
    applyStimulus(32'h0000_7000, 32'd5);
    waitCycles(15);
    checkOutput("t2_drop_cnt",  32'(o_drop_cnt), 32'd4);
    checkOutput("t2_pulses",    32'(rise_cyc_q.size()), 32'd0);
    checkOutput("t2_rdy_waits", 32'(rdy_waits), 32'd0);
    checkOutput("t2_busy",      32'(o_busy), 32'd0);

    // Six back-to-back writes: FIFO fills, all delivered in order 10 apart
    clearMonitor();
    rdy_waits = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(t3_addr[i], t3_data[i]);
      if (i == 0) e0 = last_acc;
    end
    checkOutput("t3_rdy_went_low", 32'(rdy_waits > 0), 32'd1);
    waitCycles(80);
    checkOutput("t3_pulses",  32'(rise_cyc_q.size()), 32'd6);
    checkOutput("t3_latency", 32'(qAt(rise_cyc_q, 0) - e0), 32'd1);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("t3_info_%0d", i), 32'(qAt(rise_info_q, i)), 32'(t3_info[i]));
      checkOutput($sformatf("t3_high_%0d", i), 32'(qAt(high_q, i)), 32'd2);
      if (i > 0)
        checkOutput($sformatf("t3_spacing_%0d", i),
                    32'(qAt(rise_cyc_q, i) - qAt(rise_cyc_q, i - 1)), 32'd10);
    end
    checkOutput("t3_hold_stable_errs", 32'(stab_err), 32'd0);
    checkOutput("t3_drop_unchanged", 32'(o_drop_cnt), 32'd4);

    // Drop counter saturation (4 already counted)
    for (int i = 0; i < 251; i++) applyStimulus(32'h0000_9000, 32'd0);
    checkOutput("t4_drop_at_255", 32'(o_drop_cnt), 32'd255);
    for (int i = 0; i < 49; i++) applyStimulus(32'h0000_9000, 32'd0);
    checkOutput("t4_drop_saturated", 32'(o_drop_cnt), 32'd255);

    // Reset in the middle of the second pulse with three MSIs still queued
    clearMonitor();
    for (int i = 1; i <= 5; i++) applyStimulus(32'h0000_0000, 32'(i));
    guard = 0;
    while (!(o_msi_info_vld && o_msi_info == 10'h002) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("t5_second_pulse_seen", 32'(guard < 40), 32'd1);
    rstn = 1'b0;
    #1;
    checkOutput("t5_vld",  32'(o_msi_info_vld), 32'd0);
    checkOutput("t5_info", 32'(o_msi_info),     32'd0);
    checkOutput("t5_busy", 32'(o_busy),         32'd0);
    checkOutput("t5_rdy",  32'(o_wr_rdy),       32'd1);
    checkOutput("t5_drop", 32'(o_drop_cnt),     32'd0);
    waitCycles(2);
    rstn = 1'b1;
    clearMonitor();
    waitCycles(40);
    checkOutput("t5_no_pulses_after", 32'(rise_cyc_q.size()), 32'd0);
    checkOutput("t5_busy_after",      32'(o_busy), 32'd0);

    // Write accepted on the edge where HOLD ends, then one more queued behind
    clearMonitor();
    applyStimulus(32'h0000_9000, 32'd5);
    e0 = last_acc;
    guard = 0;
    while (cyc != e0 + 10 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    applyStimulus(32'h0001_E000, 32'd31);
    applyStimulus(32'h0000_8000, 32'd3);
    waitCycles(40);
    checkOutput("t6_pulses",  32'(rise_cyc_q.size()), 32'd3);
    checkOutput("t6_info_0",  32'(qAt(rise_info_q, 0)), 32'h125);
    checkOutput("t6_info_1",  32'(qAt(rise_info_q, 1)), 32'h3DF);
    checkOutput("t6_info_2",  32'(qAt(rise_info_q, 2)), 32'h103);
    checkOutput("t6_rise_0",  32'(qAt(rise_cyc_q, 0) - e0), 32'd1);
    checkOutput("t6_rise_1",  32'(qAt(rise_cyc_q, 1) - e0), 32'd12);
    checkOutput("t6_rise_2",  32'(qAt(rise_cyc_q, 2) - e0), 32'd22);
    checkOutput("t6_hold_stable_errs", 32'(stab_err), 32'd0);
    checkOutput("t6_busy_after", 32'(o_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
